// File: rtl/lcd_text_feeder.sv
// Character buffer for the SC1602 LCD path: host writes land in a ROWS x COLS buffer,
// which is streamed to the driver once per refresh period over a valid/ready handshake.
module lcd_text_feeder #(
   parameter int          CLK_HZ     = 27_000_000,
   parameter int          REFRESH_HZ = 10,
   parameter int          COLS       = 16,
   parameter int          ROWS       = 2,
   parameter logic [7:0]  FILL_CHAR  = 8'h20,
   localparam int         N          = ROWS * COLS,
   localparam int         AW         = (N > 1) ? $clog2(N) : 1
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   output logic          wr_ready,
   input  logic          clear_req,
   input  logic          force_refresh,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_addr,
   output logic [7:0]    out_data,
   output logic          out_row_start,
   output logic          busy,
   output logic          overrun
);

   localparam int TICK = CLK_HZ / REFRESH_HZ;
   localparam int TW   = (TICK > 1) ? $clog2(TICK) : 1;
   localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SEND} state_t;

   state_t        state;
   logic [7:0]    mem [N];
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [AW-1:0] idx;
   logic [AW-1:0] next_idx;
   logic [CW-1:0] col;
   logic [CW-1:0] next_col;
   logic          last;
   logic          clear_pend;
   logic          wr_hit;

   assign tick     = (tick_cnt == TW'(TICK - 1));
   assign next_idx = idx + AW'(1);
   assign next_col = (col == CW'(COLS - 1)) ? '0 : col + CW'(1);
   assign last     = (idx == AW'(N - 1));
   assign wr_hit   = wr_en & wr_ready & (int'(wr_addr) < N);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)                    tick_cnt <= '0;
      else if (tick)                     tick_cnt <= '0;
      else                               tick_cnt <= tick_cnt + TW'(1);
   end

   // NOTE: the character array has no reset; the CLEAR state fills it after every
   // reset, which keeps it mappable onto plain RAM.
   always_ff @(posedge sys_clk) begin
      if (state == S_CLEAR)              mem[idx]     <= FILL_CHAR;
      else if (wr_hit)                   mem[wr_addr] <= wr_data;
   end

   // idx doubles as the fill pointer in CLEAR and the read pointer in SEND.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= S_CLEAR;
         idx           <= '0;
         col           <= '0;
         clear_pend    <= 1'b0;
         out_valid     <= 1'b0;
         out_addr      <= '0;
         out_data      <= FILL_CHAR;
         out_row_start <= 1'b0;
         overrun       <= 1'b0;
         wr_ready      <= 1'b0;
         busy          <= 1'b1;
      end else begin
         overrun <= tick & (state != S_IDLE);
         case (state)
            S_CLEAR: begin
               if (last) begin
                  state    <= S_IDLE;
                  idx      <= '0;
                  wr_ready <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  idx <= next_idx;
               end
            end
            S_IDLE: begin
               if (clear_req | clear_pend) begin
                  state      <= S_CLEAR;
                  idx        <= '0;
                  clear_pend <= 1'b0;
                  wr_ready   <= 1'b0;
                  busy       <= 1'b1;
               end else if (tick | force_refresh) begin
                  state         <= S_SEND;
                  idx           <= '0;
                  col           <= '0;
                  out_valid     <= 1'b1;
                  out_addr      <= '0;
                  out_data      <= mem[0];
                  out_row_start <= 1'b1;
                  busy          <= 1'b1;
               end
            end
            S_SEND: begin
               if (clear_req) clear_pend <= 1'b1;
               if (out_ready) begin
                  if (last) begin
                     state         <= S_IDLE;
                     idx           <= '0;
                     out_valid     <= 1'b0;
                     out_row_start <= 1'b0;
                     busy          <= 1'b0;
                  end else begin
                     idx           <= next_idx;
                     col           <= next_col;
                     out_addr      <= next_idx;
                     out_data      <= mem[next_idx];
                     out_row_start <= (next_col == '0);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_text_feeder.sv
// Self-checking bench for lcd_text_feeder: directed frame scenarios, a write table and
// random traffic, all compared cycle by cycle against a behavioural model.
module tb_lcd_text_feeder;

   localparam int         CLK_HZ     = 1000;
   localparam int         REFRESH_HZ = 1;
   localparam int         TICK       = CLK_HZ / REFRESH_HZ;
   localparam int         COLS       = 16;
   localparam int         ROWS       = 2;
   localparam int         N          = ROWS * COLS;
   localparam logic [7:0] FILL       = 8'h20;

   logic       sys_clk, sys_rst_n;
   logic       wr_en, wr_ready, clear_req, force_refresh;
   logic [4:0] wr_addr, out_addr;
   logic [7:0] wr_data, out_data;
   logic       out_valid, out_ready, out_row_start, busy, overrun;

   lcd_text_feeder #(.CLK_HZ(CLK_HZ), .REFRESH_HZ(REFRESH_HZ), .COLS(COLS), .ROWS(ROWS),
                     .FILL_CHAR(FILL)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .clear_req(clear_req), .force_refresh(force_refresh),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_row_start(out_row_start),
      .busy(busy), .overrun(overrun));

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural model: buffer contents plus "cycles of clearing left", "sending" and
   // the position in the frame; expected outputs follow from those.
   logic [7:0] m_mem [N];
   int         clear_left, pos, m_cycle, m_drop;
   bit         sending, pending;
   bit         e_valid, e_row, e_busy, e_wr_ready, e_overrun;
   logic [7:0] e_data;

   logic [7:0] cap [N];
   logic       cap_row [N];
   int         seen [N];
   int         n_xfer, n_ovr;

   task automatic model_step();
      bit tk;
      bit wr_ok;
      tk    = (m_cycle % TICK) == TICK - 1;
      wr_ok = wr_en && e_wr_ready && (int'(wr_addr) < N);
      m_cycle++;
      e_overrun = tk && (clear_left > 0 || sending);
      if (e_overrun) m_drop++;
      if (clear_left > 0) begin
         m_mem[N - clear_left] = FILL;
         clear_left--;
      end else if (sending) begin
         if (clear_req) pending = 1'b1;
         if (out_ready) begin
            if (pos == N - 1) sending = 1'b0;
            else begin
               pos++;
               e_data = m_mem[pos];
            end
         end
      end else if (clear_req || pending) begin
         clear_left = N;
         pending    = 1'b0;
      end else if (tk || force_refresh) begin
         sending = 1'b1;
         pos     = 0;
         e_data  = m_mem[0];
      end
      if (wr_ok) m_mem[wr_addr] = wr_data;
      e_valid    = sending;
      e_busy     = sending || clear_left > 0;
      e_wr_ready = clear_left == 0;
      e_row      = sending && (pos % COLS == 0);
   endtask

   task automatic step_cycle();
      if (out_valid && out_ready) begin
         cap[out_addr]     = out_data;
         cap_row[out_addr] = out_row_start;
         seen[out_addr]++;
         n_xfer++;
      end
      model_step();
      @(posedge sys_clk);
      #1;
      check("out_valid", out_valid, e_valid);
      check("busy", busy, e_busy);
      check("wr_ready", wr_ready, e_wr_ready);
      check("overrun", overrun, e_overrun);
      check("out_row_start", out_row_start, e_row);
      if (e_valid) begin
         check("out_addr", out_addr, pos);
         check("out_data", out_data, e_data);
      end
      if (overrun) n_ovr++;
   endtask

   task automatic frame_reset();
      n_xfer = 0;
      for (int i = 0; i < N; i++) seen[i] = 0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 200 && (out_valid || busy); i++) step_cycle();
      check({name, "_idle_timeout"}, out_valid | busy, 0);
   endtask

   task automatic wait_frame(input string name);
      for (int i = 0; i < 2 * TICK && !out_valid; i++) step_cycle();
      check({name, "_frame_timeout"}, out_valid, 1);
   endtask

   task automatic drain_frame(input string name);
      out_ready = 1'b1;
      for (int i = 0; i < 200 && out_valid; i++) step_cycle();
      check({name, "_drain_timeout"}, out_valid, 0);
   endtask

   function automatic int count_not(input logic [7:0] v);
      int c = 0;
      for (int i = 0; i < N; i++) if (cap[i] !== v) c++;
      return c;
   endfunction

   function automatic int count_not_once();
      int c = 0;
      for (int i = 0; i < N; i++) if (seen[i] != 1) c++;
      return c;
   endfunction

   typedef struct {
      logic [4:0] addr;
      logic [7:0] data;
      logic [7:0] exp_data;
      logic       exp_row;
   } vec_t;

   vec_t tbl [6];

   initial begin
      int cnt, rows;
      logic [4:0] pa;
      logic [7:0] pd;
      bit stall;

      tbl[0] = '{5'd0,  8'h48, 8'h48, 1'b1};
      tbl[1] = '{5'd17, 8'h69, 8'h69, 1'b0};
      tbl[2] = '{5'd16, 8'h2D, 8'h2D, 1'b1};
      tbl[3] = '{5'd15, 8'h41, 8'h41, 1'b0};
      tbl[4] = '{5'd31, 8'h7E, 8'h7E, 1'b0};
      tbl[5] = '{5'd1,  8'h42, 8'h42, 1'b0};

      sys_rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      clear_req = 1'b0; force_refresh = 1'b0; out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin m_mem[i] = 8'h00; cap[i] = 8'h00; cap_row[i] = 1'b0; end
      clear_left = N; pos = 0; m_cycle = 0; m_drop = 0; sending = 0; pending = 0;
      e_valid = 0; e_row = 0; e_busy = 1; e_wr_ready = 0; e_overrun = 0; e_data = FILL;
      n_ovr = 0;
      frame_reset();

      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_addr", out_addr, 0);
      check("rst_out_data", out_data, FILL);
      check("rst_row_start", out_row_start, 0);
      check("rst_overrun", overrun, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_busy", busy, 1);
      sys_rst_n = 1'b1;

      // 1: clear length after reset, then the first tick frame is all spaces.
      cnt = 0;
      for (int i = 0; i < 100 && busy; i++) begin step_cycle(); cnt++; end
      check("t1_clear_len", cnt, N);
      out_ready = 1'b1;
      wait_frame("t1");
      frame_reset();
      rows = 0;
      for (int i = 0; i < 100 && out_valid; i++) begin
         if (out_row_start) rows++;
         step_cycle();
      end
      check("t1_xfers", n_xfer, N);
      check("t1_row_starts", rows, 2);
      check("t1_non_fill", count_not(FILL), 0);

      // 2: table of writes, forced frame, back-to-back transfers.
      wait_idle("t2");
      for (int i = 0; i < 6; i++) begin
         wr_en = 1'b1; wr_addr = tbl[i].addr; wr_data = tbl[i].data;
         step_cycle();
      end
      wr_en = 1'b0;
      force_refresh = 1'b1;
      step_cycle();
      force_refresh = 1'b0;
      check("t2_valid_next_cycle", out_valid, 1);
      frame_reset();
      cnt = 0;
      for (int i = 0; i < 100 && out_valid; i++) begin step_cycle(); cnt++; end
      check("t2_frame_cycles", cnt, N);
      check("t2_xfers", n_xfer, N);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t2_data_%0d", tbl[i].addr), cap[tbl[i].addr], tbl[i].exp_data);
         check($sformatf("t2_row_%0d", tbl[i].addr), cap_row[tbl[i].addr], tbl[i].exp_row);
      end

      // 3: random backpressure keeps the presented character stable.
      wait_frame("t3");
      frame_reset();
      for (int i = 0; i < 1000 && out_valid; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         stall = out_valid && !out_ready;
         pa = out_addr; pd = out_data;
         step_cycle();
         if (stall) begin
            check("t3_stall_addr", out_addr, pa);
            check("t3_stall_data", out_data, pd);
         end
      end
      check("t3_xfers", n_xfer, N);
      check("t3_each_once", count_not_once(), 0);

      // 4: stall longer than a refresh period drops one tick with one overrun pulse.
      out_ready = 1'b1;
      wait_frame("t4");
      frame_reset();
      repeat (3) step_cycle();
      out_ready = 1'b0;
      n_ovr = 0; m_drop = 0;
      repeat (TICK + 100) step_cycle();
      check("t4_overrun_pulses", n_ovr, 1);
      check("t4_overrun_vs_model", n_ovr, m_drop);
      drain_frame("t4");
      check("t4_xfers", n_xfer, N);
      check("t4_each_once", count_not_once(), 0);

      // 5: clear at idx 5 waits for the frame, then wipes the buffer.
      wait_idle("t5");
      force_refresh = 1'b1; step_cycle(); force_refresh = 1'b0;
      frame_reset();
      for (int i = 0; i < 40 && !(out_valid && out_addr == 5); i++) step_cycle();
      check("t5_reach_idx5", out_addr, 5);
      clear_req = 1'b1; step_cycle(); clear_req = 1'b0;
      drain_frame("t5");
      check("t5_xfers", n_xfer, N);
      check("t5_old_addr0", cap[0], 8'h48);
      check("t5_old_addr17", cap[17], 8'h69);
      cnt = 0;
      for (int i = 0; i < 100 && (cnt == 0 || !wr_ready); i++) begin
         step_cycle();
         if (!wr_ready) cnt++;
      end
      check("t5_clear_len", cnt, N);
      force_refresh = 1'b1; step_cycle(); force_refresh = 1'b0;
      frame_reset();
      drain_frame("t5b");
      check("t5_cleared_frame", count_not(FILL), 0);

      // 6: writing the presented address while stalled only shows up next frame.
      wait_idle("t6");
      force_refresh = 1'b1; step_cycle(); force_refresh = 1'b0;
      for (int i = 0; i < 40 && !(out_valid && out_addr == 10); i++) step_cycle();
      check("t6_reach_idx10", out_addr, 10);
      out_ready = 1'b0;
      step_cycle();
      wr_en = 1'b1; wr_addr = 5'd10; wr_data = 8'h5A;
      step_cycle();
      wr_en = 1'b0;
      step_cycle();
      check("t6_stalled_data", out_data, FILL);
      drain_frame("t6");
      check("t6_old_transferred", cap[10], FILL);
      force_refresh = 1'b1; step_cycle(); force_refresh = 1'b0;
      drain_frame("t6b");
      check("t6_new_next_frame", cap[10], 8'h5A);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         wr_en         = ($urandom_range(0, 3) == 0);
         wr_addr       = 5'($urandom);
         wr_data       = 8'($urandom);
         clear_req     = ($urandom_range(0, 299) == 0);
         force_refresh = ($urandom_range(0, 49) == 0);
         out_ready     = ($urandom_range(0, 3) != 0);
         step_cycle();
      end
      wr_en = 1'b0; clear_req = 1'b0; force_refresh = 1'b0;
      drain_frame("rand");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1);
   end

endmodule
